food_placer: RTL and testbench
==============================

# food_placer

Consumes the free-running random coordinate pair (`randX`, `randY`) and turns it into a legal food position for the snake game. On a `start` or `eaten` trigger, it samples the generator and snaps the sample to the cell grid. It then range-checks the cell against the play area and queries the snake-body logic for occupancy, retrying until it finds a free cell. Sits between the random generator and the renderer/collision logic, clocked on `VGA_clk`.

## Interface
- `CELL_SHIFT`, 4: cell size is 2^CELL_SHIFT pixels; coordinates snap to multiples of it.
- `X_MIN`, 16: smallest legal cell-origin X, inclusive.
- `X_MAX`, 592: largest legal cell-origin X, inclusive.
- `Y_MIN`, 16: smallest legal cell-origin Y, inclusive.
- `Y_MAX`, 448: largest legal cell-origin Y, inclusive.
- `MAX_TRIES`, 8: number of samples attempted per trigger before giving up (1..255).
- `RESET_X`, 320: `appleX` value on reset.
- `RESET_Y`, 240: `appleY` value on reset.
- `VGA_clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `randX`  in  10  random X from the generator; sampled only in SAMPLE.
- `randY`  in  9  random Y from the generator; sampled only in SAMPLE.
- `start`  in  1  game-start pulse; a placement trigger.
- `eaten`  in  1  food-eaten pulse; a placement trigger.
- `occ_req`  out  1  occupancy query valid.
- `occ_x`  out  10  queried cell X; stable while `occ_req`=1.
- `occ_y`  out  9  queried cell Y; stable while `occ_req`=1.
- `occ_ack`  in  1  query answered this cycle.
- `occ_hit`  in  1  cell occupied by snake; qualified by `occ_ack`.
- `appleX`  out  10  committed food X, registered.
- `appleY`  out  9  committed food Y, registered.
- `apple_valid`  out  1  food position valid and visible.
- `busy`  out  1  placement in progress.
- `place_fail`  out  1  one-cycle pulse when tries are exhausted.

## Operation
- Snap rule: `cx = randX & ~(2^CELL_SHIFT-1)`, `cy = randY & ~(2^CELL_SHIFT-1)`, using the native widths (10 and 9 bits). No arithmetic overflow is possible.
- Legal cell: `X_MIN<=cx<=X_MAX` and `Y_MIN<=cy<=Y_MAX`, as unsigned compares.
- States are IDLE, SAMPLE, CHECK, WAIT.
- **IDLE:** `start|eaten` moves to SAMPLE. On the same edge, `busy`<=1, `apple_valid`<=0 and `tries`<=0. Simultaneous `start` and `eaten` count as one trigger.
- **SAMPLE:** latches `cx`/`cy` into `occ_x`/`occ_y`, sets `tries`<=`tries`+1, then moves to CHECK.
- **CHECK:**
  - If the cell is illegal and `tries`==`MAX_TRIES`, go to FAIL.
  - If the cell is illegal and `tries`<`MAX_TRIES`, go to SAMPLE.
  - If the cell is legal, set `occ_req`<=1 and go to WAIT.
- **WAIT:** holds `occ_req`, `occ_x` and `occ_y` until `occ_ack`=1. On the ack edge, `occ_req`<=0, then:
  - If `occ_hit`=1, apply the CHECK retry/FAIL rule.
  - If `occ_hit`=0, set `appleX`<=`occ_x`, `appleY`<=`occ_y`, `apple_valid`<=1, `busy`<=0, and return to IDLE.
- **FAIL action (not a state):** `place_fail`<=1 for exactly one cycle, `busy`<=0, `apple_valid` stays 0, next state IDLE. The previous `appleX`/`appleY` are retained. A new trigger restarts placement.
- Triggers arriving while `busy`=1 are ignored, not queued.
- `occ_ack` outside WAIT is ignored.
- **Reset (asynchronous, any state including mid-WAIT):**
  - State IDLE.
  - `appleX`=`RESET_X`, `appleY`=`RESET_Y`.
  - `apple_valid`=0, `busy`=0, `occ_req`=0, `place_fail`=0.
  - `occ_x`=0, `occ_y`=0, `tries`=0.

## Timing
- Take edge 0 as the trigger edge.
- Edge 1 is SAMPLE, edge 2 is CHECK, and `occ_req` is high from edge 2.
- With `occ_ack` high in the first WAIT cycle, `apple_valid` rises after edge 3 (3-cycle minimum latency).
- Each range rejection costs 2 cycles (SAMPLE→CHECK).
- Each occupancy rejection costs 3 cycles plus the ack wait.
- All outputs are registered; no combinational path runs from inputs to outputs.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle.
  - Outputs immediately show `appleX`=320, `appleY`=240 and all flags 0.
- **Basic placement:** hold `randX`=205, `randY`=100; pulse `eaten`; the responder acks in the same cycle with `occ_hit`=0.
  - `occ_x`=192, `occ_y`=96.
  - `apple_valid`=1 with `appleX`=192, `appleY`=96 after edge 3.
  - `busy` high for edges 0–3.
- **Range reject:** first sample `randX`=5, `randY`=100, then `randX`=300.
  - No `occ_req` for the first sample.
  - Final `appleX`=288, `appleY`=96.
- **Occupied reject:** first query answered `occ_hit`=1 after 2 wait cycles, then `randX`=400, `randY`=200 answered free.
  - Commit `appleX`=400, `appleY`=192.
  - `occ_req` drops for at least 2 cycles between the queries.
- **Exhaustion:** `occ_hit` always 1.
  - Exactly 8 `occ_req` assertions.
  - `place_fail` high for 1 cycle; `apple_valid`=0; `busy`=0; previous `appleX`/`appleY` unchanged.
- **Ignored trigger and mid-WAIT reset:**
  - Pulse `eaten` while `busy`=1: no extra placement.
  - Assert `rst` during WAIT: `occ_req`=0 before the next edge, and the FSM restarts cleanly on the next `start`.

Source files
------------

// File: rtl/food_placer.sv
// ----------------------------------------------------------------------------
// food_placer: snaps a random sample to the cell grid, range/occupancy-checks
// it and commits a free cell as the food position.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module food_placer #(
  parameter int CELL_SHIFT = 4,
  parameter int X_MIN      = 16,
  parameter int X_MAX      = 592,
  parameter int Y_MIN      = 16,
  parameter int Y_MAX      = 448,
  parameter int MAX_TRIES  = 8,
  parameter int RESET_X    = 320,
  parameter int RESET_Y    = 240
) (
  input  logic       VGA_clk,
  input  logic       rst,
  input  logic [9:0] randX,
  input  logic [8:0] randY,
  input  logic       start,
  input  logic       eaten,
  output logic       occ_req,
  output logic [9:0] occ_x,
  output logic [8:0] occ_y,
  input  logic       occ_ack,
  input  logic       occ_hit,
  output logic [9:0] appleX,
  output logic [8:0] appleY,
  output logic       apple_valid,
  output logic       busy,
  output logic       place_fail
);

  localparam logic [9:0] X_MASK = ~10'((1 << CELL_SHIFT) - 1);
  localparam logic [8:0] Y_MASK = ~9'((1 << CELL_SHIFT) - 1);
  localparam logic [9:0] X_LO   = 10'(X_MIN);
  localparam logic [9:0] X_HI   = 10'(X_MAX);
  localparam logic [8:0] Y_LO   = 9'(Y_MIN);
  localparam logic [8:0] Y_HI   = 9'(Y_MAX);
  localparam logic [7:0] TRY_LIMIT = 8'(MAX_TRIES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    CHECK  = 2'd2,
    WAIT   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] tries_q, tries_d;
  logic [9:0] occ_x_q, occ_x_d;
  logic [8:0] occ_y_q, occ_y_d;
  logic [9:0] apple_x_q, apple_x_d;
  logic [8:0] apple_y_q, apple_y_d;
  logic       occ_req_q, occ_req_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       fail_q, fail_d;
  logic       cell_legal;
  logic       last_try;

  assign cell_legal = (occ_x_q >= X_LO) && (occ_x_q <= X_HI) &&
                      (occ_y_q >= Y_LO) && (occ_y_q <= Y_HI);
  assign last_try   = (tries_q == TRY_LIMIT);

  always_comb begin
    state_d   = state_q;
    tries_d   = tries_q;
    occ_x_d   = occ_x_q;
    occ_y_d   = occ_y_q;
    apple_x_d = apple_x_q;
    apple_y_d = apple_y_q;
    occ_req_d = occ_req_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    fail_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start || eaten) begin
          state_d = SAMPLE;
          busy_d  = 1'b1;
          valid_d = 1'b0;
          tries_d = 8'd0;
        end
      end
      SAMPLE: begin
        occ_x_d = randX & X_MASK;
        occ_y_d = randY & Y_MASK;
        tries_d = tries_q + 8'd1;
        state_d = CHECK;
      end
      CHECK: begin
        if (cell_legal) begin
          occ_req_d = 1'b1;
          state_d   = WAIT;
        end else if (last_try) begin
          fail_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = SAMPLE;
        end
      end
      WAIT: begin
        if (occ_ack) begin
          occ_req_d = 1'b0;
          if (!occ_hit) begin
            apple_x_d = occ_x_q;
            apple_y_d = occ_y_q;
            valid_d   = 1'b1;
            busy_d    = 1'b0;
            state_d   = IDLE;
          end else if (last_try) begin
            // Out of tries: keep the old food position, report the failure.
            fail_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = SAMPLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge VGA_clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tries_q   <= 8'd0;
      occ_x_q   <= 10'd0;
      occ_y_q   <= 9'd0;
      apple_x_q <= 10'(RESET_X);
      apple_y_q <= 9'(RESET_Y);
      occ_req_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tries_q   <= tries_d;
      occ_x_q   <= occ_x_d;
      occ_y_q   <= occ_y_d;
      apple_x_q <= apple_x_d;
      apple_y_q <= apple_y_d;
      occ_req_q <= occ_req_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      fail_q    <= fail_d;
    end
  end

  assign occ_req     = occ_req_q;
  assign occ_x       = occ_x_q;
  assign occ_y       = occ_y_q;
  assign appleX      = apple_x_q;
  assign appleY      = apple_y_q;
  assign apple_valid = valid_q;
  assign busy        = busy_q;
  assign place_fail  = fail_q;

endmodule

`default_nettype wire

// File: tb/tb_food_placer.sv
// ----------------------------------------------------------------------------
// tb_food_placer: directed and randomized bench for food_placer with a
// behavioural placement model.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_food_placer;

  localparam int CELL      = 16;
  localparam int MAX_TRIES = 8;

  logic       VGA_clk = 1'b0;
  logic       rst;
  logic [9:0] randX;
  logic [8:0] randY;
  logic       start, eaten;
  logic       occ_req;
  logic [9:0] occ_x;
  logic [8:0] occ_y;
  logic       occ_ack, occ_hit;
  logic [9:0] appleX;
  logic [8:0] appleY;
  logic       apple_valid, busy, place_fail;

  // stimulus sources
  logic       rand_in, rand_resp;
  logic [9:0] drv_x, rnd_x;
  logic [8:0] drv_y, rnd_y;
  logic       drv_start, drv_eaten, rnd_start, rnd_eaten;
  int         resp_delay, hit_quota;

  // responder / monitor state
  int         wait_cnt, hits_given;
  int         req_rises, busy_cnt, fail_cnt, low_run, last_gap;
  logic       prev_req;

  // model outputs
  logic [9:0] m_ax, m_ox;
  logic [8:0] m_ay, m_oy;
  logic       m_valid, m_busy, m_req, m_fail;

  int checks, errors;

  assign randX = rand_in ? rnd_x : drv_x;
  assign randY = rand_in ? rnd_y : drv_y;
  assign start = rand_in ? rnd_start : drv_start;
  assign eaten = rand_in ? rnd_eaten : drv_eaten;

  food_placer dut (
    .VGA_clk(VGA_clk), .rst(rst), .randX(randX), .randY(randY),
    .start(start), .eaten(eaten), .occ_req(occ_req), .occ_x(occ_x),
    .occ_y(occ_y), .occ_ack(occ_ack), .occ_hit(occ_hit), .appleX(appleX),
    .appleY(appleY), .apple_valid(apple_valid), .busy(busy),
    .place_fail(place_fail)
  );

  always #5 VGA_clk = ~VGA_clk;

  always @(negedge VGA_clk) begin
    rnd_x     <= 10'($urandom_range(0, 1023));
    rnd_y     <= 9'($urandom_range(0, 511));
    rnd_start <= ($urandom_range(0, 15) == 0);
    rnd_eaten <= ($urandom_range(0, 15) == 0);
  end

  initial begin
    occ_ack = 1'b0; occ_hit = 1'b0; wait_cnt = 0; hits_given = 0;
  end

  always @(negedge VGA_clk) begin
    if (rand_resp) begin
      if (occ_req) begin
        occ_ack = ($urandom_range(0, 2) == 0);
        occ_hit = ($urandom_range(0, 2) == 0);
      end else begin
        occ_ack = ($urandom_range(0, 3) == 0);
        occ_hit = 1'($urandom_range(0, 1));
      end
    end else if (occ_req) begin
      if (wait_cnt >= resp_delay) begin
        occ_ack = 1'b1;
        occ_hit = (hits_given < hit_quota);
        if (occ_hit) hits_given++;
      end else begin
        occ_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      occ_ack = 1'b0; occ_hit = 1'b0; wait_cnt = 0;
    end
  end

  initial begin
    req_rises = 0; busy_cnt = 0; fail_cnt = 0; low_run = 0; last_gap = 0;
    prev_req = 1'b0;
  end

  always @(negedge VGA_clk) begin
    if (occ_req && !prev_req) begin
      req_rises++;
      last_gap = low_run;
    end
    low_run  = occ_req ? 0 : low_run + 1;
    prev_req = occ_req;
    if (busy) busy_cnt++;
    if (place_fail) fail_cnt++;
  end

  // ---------------- behavioural model ----------------
  task automatic model_reset();
    m_ax = 10'd320; m_ay = 9'd240; m_ox = 10'd0; m_oy = 9'd0;
    m_valid = 1'b0; m_busy = 1'b0; m_req = 1'b0; m_fail = 1'b0;
  endtask

  task automatic step(output bit ab);
    @(posedge VGA_clk or posedge rst);
    ab = rst;
    if (ab) model_reset();
  endtask

  task automatic place();
    bit ab;
    int cx, cy;
    for (int t = 1; t <= MAX_TRIES; t++) begin
      step(ab); if (ab) return;
      cx = (int'(randX) / CELL) * CELL;
      cy = (int'(randY) / CELL) * CELL;
      m_ox = 10'(cx); m_oy = 9'(cy);
      step(ab); if (ab) return;
      if (cx >= 16 && cx <= 592 && cy >= 16 && cy <= 448) begin
        m_req = 1'b1;
        do begin
          step(ab); if (ab) return;
        end while (!occ_ack);
        m_req = 1'b0;
        if (!occ_hit) begin
          m_ax = 10'(cx); m_ay = 9'(cy); m_valid = 1'b1; m_busy = 1'b0;
          return;
        end
      end
    end
    m_fail = 1'b1;
    m_busy = 1'b0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge VGA_clk or posedge rst);
      if (rst) begin
        model_reset();
      end else begin
        m_fail = 1'b0;
        if (start || eaten) begin
          m_busy = 1'b1; m_valid = 1'b0;
          place();
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge VGA_clk);
      chk("cyc appleX", 32'(appleX), 32'(m_ax));
      chk("cyc appleY", 32'(appleY), 32'(m_ay));
      chk("cyc apple_valid", 32'(apple_valid), 32'(m_valid));
      chk("cyc busy", 32'(busy), 32'(m_busy));
      chk("cyc occ_req", 32'(occ_req), 32'(m_req));
      chk("cyc place_fail", 32'(place_fail), 32'(m_fail));
      if (occ_req) begin
        chk("cyc occ_x", 32'(occ_x), 32'(m_ox));
        chk("cyc occ_y", 32'(occ_y), 32'(m_oy));
      end
    end
  endtask

  task automatic trig(input bit use_start, input logic [9:0] x1, input logic [8:0] y1,
                      input logic [9:0] x2, input logic [8:0] y2);
    @(negedge VGA_clk);
    drv_x = x1; drv_y = y1;
    if (use_start) drv_start = 1'b1; else drv_eaten = 1'b1;
    @(negedge VGA_clk);
    drv_start = 1'b0; drv_eaten = 1'b0;
    @(negedge VGA_clk);
    drv_x = x2; drv_y = y2;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    @(negedge VGA_clk);
    while (busy && n < 300) begin
      @(negedge VGA_clk);
      n++;
    end
    #1;
    chk(name, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge VGA_clk);
    #2 rst = 1'b1;
    #1;
    chk("rst appleX", 32'(appleX), 32'd320);
    chk("rst appleY", 32'(appleY), 32'd240);
    chk("rst flags", {28'd0, apple_valid, busy, occ_req, place_fail}, 32'd0);
    chk("rst occ_x", 32'(occ_x), 32'd0);
    @(negedge VGA_clk);
    @(negedge VGA_clk);
    rst = 1'b0;
  endtask

  initial begin
    int r0, b0, f0;
    checks = 0; errors = 0;
    rst = 1'b1; rand_in = 1'b0; rand_resp = 1'b0;
    drv_x = 10'd0; drv_y = 9'd0; drv_start = 1'b0; drv_eaten = 1'b0;
    resp_delay = 0; hit_quota = 0;
    fork compare_loop(); join_none
    repeat (3) @(negedge VGA_clk);
    rst = 1'b0;
    repeat (2) @(negedge VGA_clk);
    do_reset();

    // basic placement, immediate free ack
    hit_quota = hits_given; resp_delay = 0;
    r0 = req_rises; b0 = busy_cnt;
    trig(1'b0, 10'd205, 9'd100, 10'd205, 9'd100);
    #1;
    chk("basic occ_x", 32'(occ_x), 32'd192);
    chk("basic occ_y", 32'(occ_y), 32'd96);
    wait_done("basic done");
    chk("basic appleX", 32'(appleX), 32'd192);
    chk("basic appleY", 32'(appleY), 32'd96);
    chk("basic valid", 32'(apple_valid), 32'd1);
    chk("basic busy cycles", 32'(busy_cnt - b0), 32'd3);
    chk("basic req count", 32'(req_rises - r0), 32'd1);

    // range reject then legal
    r0 = req_rises;
    trig(1'b0, 10'd5, 9'd100, 10'd300, 9'd100);
    wait_done("range done");
    chk("range appleX", 32'(appleX), 32'd288);
    chk("range appleY", 32'(appleY), 32'd96);
    chk("range req count", 32'(req_rises - r0), 32'd1);

    // occupied reject after 2 wait cycles, then free
    hit_quota = hits_given + 1; resp_delay = 2;
    r0 = req_rises;
    trig(1'b0, 10'd205, 9'd100, 10'd400, 9'd200);
    wait_done("occ done");
    chk("occ appleX", 32'(appleX), 32'd400);
    chk("occ appleY", 32'(appleY), 32'd192);
    chk("occ req count", 32'(req_rises - r0), 32'd2);
    chk("occ req gap", 32'(last_gap), 32'd2);

    // exhaustion: every query occupied
    hit_quota = hits_given + 1000; resp_delay = 0;
    r0 = req_rises; f0 = fail_cnt;
    trig(1'b0, 10'd205, 9'd100, 10'd205, 9'd100);
    wait_done("exh done");
    @(negedge VGA_clk); #1;
    chk("exh req count", 32'(req_rises - r0), 32'd8);
    chk("exh fail pulses", 32'(fail_cnt - f0), 32'd1);
    chk("exh valid", 32'(apple_valid), 32'd0);
    chk("exh appleX", 32'(appleX), 32'd400);
    chk("exh appleY", 32'(appleY), 32'd192);

    // trigger while busy is ignored
    hit_quota = hits_given; resp_delay = 3;
    r0 = req_rises;
    trig(1'b0, 10'd205, 9'd100, 10'd205, 9'd100);
    drv_eaten = 1'b1;
    @(negedge VGA_clk);
    drv_eaten = 1'b0;
    wait_done("ign done");
    repeat (10) @(negedge VGA_clk);
    #1;
    chk("ign req count", 32'(req_rises - r0), 32'd1);
    chk("ign busy", 32'(busy), 32'd0);
    chk("ign valid", 32'(apple_valid), 32'd1);

    // reset in the middle of WAIT, then clean restart
    resp_delay = 1000;
    trig(1'b0, 10'd205, 9'd100, 10'd205, 9'd100);
    for (int i = 0; i < 10 && !occ_req; i++) @(negedge VGA_clk);
    chk("midwait req", 32'(occ_req), 32'd1);
    do_reset();
    resp_delay = 0;
    trig(1'b1, 10'd400, 9'd200, 10'd400, 9'd200);
    wait_done("restart done");
    chk("restart appleX", 32'(appleX), 32'd400);
    chk("restart appleY", 32'(appleY), 32'd192);
    chk("restart valid", 32'(apple_valid), 32'd1);

    // randomized traffic with a reset in the middle
    @(negedge VGA_clk);
    rand_resp = 1'b1; rand_in = 1'b1;
    repeat (1500) @(negedge VGA_clk);
    do_reset();
    repeat (1500) @(negedge VGA_clk);
    rand_in = 1'b0;
    wait_done("random drain");
    @(negedge VGA_clk);
    rand_resp = 1'b0;
    repeat (3) @(negedge VGA_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
